// File: rtl/map_table_pkg.sv
// Shared types and sizes for the rename map table and its forwarding helper.
// Holds no logic. Physical tag width comes from PHYS_REG_ID_BITS, which defaults to 6 when not set globally.
// Backpressure does not apply here; the consuming modules define their own timing.
`ifndef PHYS_REG_ID_BITS
`define PHYS_REG_ID_BITS 6
`endif

package map_table_pkg;

    // Architectural register file size and index width.
    localparam int ARCH_REG_SZ   = 32;
    localparam int ARCH_IDX_BITS = $clog2(ARCH_REG_SZ);

    // Physical tag width, shared with the free list and the ROB.
    localparam int PHYS_IDX_BITS = `PHYS_REG_ID_BITS;

    // Default dispatch width, in instructions renamed per cycle.
    localparam int NUM_LANES = 4;

    typedef logic [ARCH_IDX_BITS-1:0] ARCH_REG_IDX;
    typedef logic [PHYS_IDX_BITS-1:0] PHYS_REG_IDX;

    // One map table entry: the current physical tag and whether its value has been produced.
    typedef struct packed {
        PHYS_REG_IDX phys;
        logic        ready;
    } MAP_ENTRY;

    // Identity mapping used at reset: arch register i lives in phys i and is already valid.
    function automatic MAP_ENTRY reset_entry(input int idx);
        MAP_ENTRY e;
        e.phys  = PHYS_REG_IDX'(idx);
        e.ready = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/rename_group_forward.sv
// Intra-group forwarding. Finds the youngest older lane in the same dispatch group whose destination matches the query.
// Purely combinational, with zero latency.
// There is no flow control. Invalid lanes are masked out through lane_valid.
module rename_group_forward
    import map_table_pkg::*;
#(
    parameter int N    = NUM_LANES,
    parameter int LANE = 0
)(
    input  logic [N-1:0]                    lane_valid,
    input  logic [N-1:0][ARCH_IDX_BITS-1:0] group_dest,
    input  logic [N-1:0][PHYS_IDX_BITS-1:0] group_phys,
    input  ARCH_REG_IDX                     query,
    output logic                            hit,
    output PHYS_REG_IDX                     phys
);

    // Scan older lanes in ascending order so the highest matching lane wins. Dest x0 never forwards.
    always_comb begin
        hit  = 1'b0;
        phys = '0;
        for (int i = 0; i < N; i++) begin
            if ((i < LANE) && lane_valid[i] &&
                (group_dest[i] != '0) && (group_dest[i] == query)) begin
                hit  = 1'b1;
                phys = group_phys[i];
            end
        end
    end

endmodule

// File: rtl/map_table.sv
// R10K rename map table. Renames up to N lanes per cycle, returns T_old, tracks CDB ready bits and restores on mispredict.
// Lookups are combinational with zero latency. Table updates become visible on the cycle after the edge.
// There is no handshake: a stall is num_renaming == 0. MAP_TABLE_CDB_BYPASS_EN adds a same-cycle CDB wakeup for table reads.
module map_table
    import map_table_pkg::*;
#(
    parameter  int ARCH_REGS = ARCH_REG_SZ,
    parameter  int PHYS_BITS = PHYS_IDX_BITS,
    parameter  int N         = NUM_LANES,
    localparam int IDX_BITS  = $clog2(ARCH_REGS),
    localparam int CNT_BITS  = $clog2(N + 1)
)(
    input  logic                                clock,
    input  logic                                reset,
    input  logic [CNT_BITS-1:0]                 num_renaming,
    input  logic [N-1:0][IDX_BITS-1:0]          rename_src1,
    input  logic [N-1:0][IDX_BITS-1:0]          rename_src2,
    input  logic [N-1:0][IDX_BITS-1:0]          rename_dest,
    input  logic [N-1:0][PHYS_BITS-1:0]         new_phys,
    output logic [N-1:0][PHYS_BITS-1:0]         src1_phys,
    output logic [N-1:0][PHYS_BITS-1:0]         src2_phys,
    output logic [N-1:0]                        src1_ready,
    output logic [N-1:0]                        src2_ready,
    output logic [N-1:0][PHYS_BITS-1:0]         old_phys,
    input  logic [N-1:0]                        cdb_valid,
    input  logic [N-1:0][PHYS_BITS-1:0]         cdb_tag,
    input  logic                                restore,
    input  logic [ARCH_REGS-1:0][PHYS_BITS-1:0] restore_map
);

    MAP_ENTRY     map_q [ARCH_REGS];
    MAP_ENTRY     map_d [ARCH_REGS];
    logic [N-1:0] lane_valid;

    // True when any valid CDB lane broadcasts this tag.
    function automatic logic cdb_match(input PHYS_REG_IDX tag);
        logic m;
        m = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (cdb_valid[c] && (cdb_tag[c] == tag)) begin
                m = 1'b1;
            end
        end
        return m;
    endfunction

    // Lanes below num_renaming take part in this group. All other lanes are ignored.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            lane_valid[l] = (CNT_BITS'(l) < num_renaming);
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic        s1_hit;
        logic        s2_hit;
        logic        old_hit;
        PHYS_REG_IDX s1_fwd;
        PHYS_REG_IDX s2_fwd;
        PHYS_REG_IDX old_fwd;
        MAP_ENTRY    e1;
        MAP_ENTRY    e2;
        MAP_ENTRY    eo;
        PHYS_REG_IDX s1_p;
        PHYS_REG_IDX s2_p;
        PHYS_REG_IDX old_p;
        logic        s1_r;
        logic        s2_r;

        rename_group_forward #(.N(N), .LANE(l)) u_fwd_src1 (
            .lane_valid (lane_valid),
            .group_dest (rename_dest),
            .group_phys (new_phys),
            .query      (rename_src1[l]),
            .hit        (s1_hit),
            .phys       (s1_fwd)
        );

        rename_group_forward #(.N(N), .LANE(l)) u_fwd_src2 (
            .lane_valid (lane_valid),
            .group_dest (rename_dest),
            .group_phys (new_phys),
            .query      (rename_src2[l]),
            .hit        (s2_hit),
            .phys       (s2_fwd)
        );

        rename_group_forward #(.N(N), .LANE(l)) u_fwd_old (
            .lane_valid (lane_valid),
            .group_dest (rename_dest),
            .group_phys (new_phys),
            .query      (rename_dest[l]),
            .hit        (old_hit),
            .phys       (old_fwd)
        );

        assign e1 = map_q[rename_src1[l]];
        assign e2 = map_q[rename_src2[l]];
        assign eo = map_q[rename_dest[l]];

        // Source resolution, in increasing priority: table read (with optional CDB bypass), then forced x0, then group forwarding.
        always_comb begin
            s1_p = e1.phys;
            s2_p = e2.phys;
`ifdef MAP_TABLE_CDB_BYPASS_EN
            s1_r = e1.ready | cdb_match(e1.phys);
            s2_r = e2.ready | cdb_match(e2.phys);
`else
            s1_r = e1.ready;
            s2_r = e2.ready;
`endif
            if (rename_src1[l] == '0) begin
                s1_p = '0;
                s1_r = 1'b1;
            end
            if (rename_src2[l] == '0) begin
                s2_p = '0;
                s2_r = 1'b1;
            end
            if (s1_hit) begin
                s1_p = s1_fwd;
                s1_r = 1'b0;
            end
            if (s2_hit) begin
                s2_p = s2_fwd;
                s2_r = 1'b0;
            end
        end

        // T_old comes from an older lane's new tag if one renamed the same dest, otherwise from the table. Dest x0 yields 0.
        always_comb begin
            old_p = eo.phys;
            if (rename_dest[l] == '0) begin
                old_p = '0;
            end
            if (old_hit) begin
                old_p = old_fwd;
            end
        end

        assign src1_phys[l]  = s1_p;
        assign src2_phys[l]  = s2_p;
        assign src1_ready[l] = s1_r;
        assign src2_ready[l] = s2_r;
        assign old_phys[l]   = old_p;
    end

    // Next table state. CDB wakeups apply first. Rename writes then overwrite them, in lane order so the youngest duplicate dest wins.
    always_comb begin
        for (int e = 0; e < ARCH_REGS; e++) begin
            map_d[e] = map_q[e];
            if (cdb_match(map_q[e].phys)) begin
                map_d[e].ready = 1'b1;
            end
        end
        for (int l = 0; l < N; l++) begin
            if (lane_valid[l] && (rename_dest[l] != '0)) begin
                map_d[rename_dest[l]].phys  = new_phys[l];
                map_d[rename_dest[l]].ready = 1'b0;
            end
        end
    end

    // Table register. Reset restores the identity map. Restore loads the retirement map and discards this cycle's renames and wakeups.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < ARCH_REGS; e++) begin
                map_q[e] <= reset_entry(e);
            end
        end else if (restore) begin
            for (int e = 0; e < ARCH_REGS; e++) begin
                map_q[e].phys  <= restore_map[e];
                map_q[e].ready <= 1'b1;
            end
        end else begin
            map_q <= map_d;
        end
    end

endmodule
